// File: rtl/mem_access.sv
// Memory-access pipeline stage: word/byte loads and stores over a req/ready
// data-memory handshake, stalling upstream while an access is outstanding.
module mem_access #(
  parameter int DMEM_AW = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               memRead,
  input  logic               memWrite,
  input  logic               word,
  input  logic               regWrite,
  input  logic [31:0]        result,
  input  logic [31:0]        readData2,
  input  logic [4:0]         rd,
  output logic               stall,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [31:0]        dmem_wdata,
  output logic [3:0]         dmem_be,
  input  logic               dmem_ready,
  input  logic [31:0]        dmem_rdata,
  output logic               wb_regWrite,
  output logic [4:0]         wb_rd,
  output logic [31:0]        wb_data,
  output logic               align_fault
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [4:0]         rd_q, rd_d;
  logic               rw_q, rw_d, ld_q, ld_d, word_q, word_d;
  logic [1:0]         off_q, off_d;
  logic               req_q, req_d, we_q, we_d;
  logic [DMEM_AW-1:0] addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         be_q, be_d;
  logic               wbrw_q, wbrw_d;
  logic [4:0]         wbrd_q, wbrd_d;
  logic [31:0]        wbdata_q, wbdata_d;
  logic               fault_q, fault_d;

  logic        mem_op, misalign, issue;
  logic [31:0] lane_sh, load_val;

  assign mem_op   = memRead | memWrite;
  assign misalign = word & (result[1:0] != 2'b00);
  assign issue    = (state_q == IDLE) & mem_op & ~misalign;
  assign stall    = issue | ((state_q == WAIT) & ~dmem_ready);

  assign lane_sh  = dmem_rdata >> {off_q, 3'b000};
  assign load_val = word_q ? dmem_rdata : {{24{lane_sh[7]}}, lane_sh[7:0]};

  always_comb begin
    state_d  = state_q;
    rd_d     = rd_q;
    rw_d     = rw_q;
    ld_d     = ld_q;
    word_d   = word_q;
    off_d    = off_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    wbrw_d   = 1'b0;
    wbrd_d   = wbrd_q;
    wbdata_d = wbdata_q;
    fault_d  = 1'b0;
    if (state_q == IDLE) begin
      if (!mem_op) begin
        wbrw_d   = regWrite;
        wbrd_d   = rd;
        wbdata_d = result;
      end else if (misalign) begin
        fault_d = 1'b1;
      end else begin
        state_d = WAIT;
        rd_d    = rd;
        rw_d    = regWrite;
        // Both read and write set is illegal; the write wins.
        ld_d    = memRead & ~memWrite;
        word_d  = word;
        off_d   = result[1:0];
        req_d   = 1'b1;
        we_d    = memWrite;
        addr_d  = {result[DMEM_AW-1:2], 2'b00};
        be_d    = word ? 4'b1111 : (4'b0001 << result[1:0]);
        wdata_d = word ? readData2 : {4{readData2[7:0]}};
      end
    end else if (dmem_ready) begin
      state_d = IDLE;
      req_d   = 1'b0;
      if (ld_q) begin
        wbrw_d   = rw_q;
        wbrd_d   = rd_q;
        wbdata_d = load_val;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      rd_q     <= '0;
      rw_q     <= 1'b0;
      ld_q     <= 1'b0;
      word_q   <= 1'b0;
      off_q    <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      wbrw_q   <= 1'b0;
      wbrd_q   <= '0;
      wbdata_q <= '0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_q     <= rd_d;
      rw_q     <= rw_d;
      ld_q     <= ld_d;
      word_q   <= word_d;
      off_q    <= off_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      wbrw_q   <= wbrw_d;
      wbrd_q   <= wbrd_d;
      wbdata_q <= wbdata_d;
      fault_q  <= fault_d;
    end
  end

  assign dmem_req    = req_q;
  assign dmem_we     = we_q;
  assign dmem_addr   = addr_q;
  assign dmem_wdata  = wdata_q;
  assign dmem_be     = be_q;
  assign wb_regWrite = wbrw_q;
  assign wb_rd       = wbrd_q;
  assign wb_data     = wbdata_q;
  assign align_fault = fault_q;
endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the five-stage pipeline, sitting between the EX/MEM pipeline register and the MEM/WB register. It consumes the registered EX/MEM control bits, ALU result (address), store data and destination register. It performs word or byte loads and stores over a request/ready data-memory handshake, stalling the upstream pipeline while an access is outstanding. It produces the registered writeback bundle.

## Interface
- Parameters:
- `DMEM_AW`, default 32: data-memory address width; the address is `result[DMEM_AW-1:0]`.
- Ports:
- `clock`  in  1  single pipeline clock, rising edge.
- `reset`  in  1  synchronous, active-high; clears state and every registered output.
- `memRead`  in  1  EX/MEM: instruction is a load.
- `memWrite`  in  1  EX/MEM: instruction is a store.
- `word`  in  1  EX/MEM: 1 = word access, 0 = byte access.
- `regWrite`  in  1  EX/MEM: instruction writes the register file.
- `result`  in  32  EX/MEM ALU result: address for memory ops, data otherwise.
- `readData2`  in  32  EX/MEM store data.
- `rd`  in  5  EX/MEM destination register.
- `stall`  out  1  combinational; 1 = EX/MEM and earlier stages hold.
- `dmem_req`  out  1  registered; access request, held until `dmem_ready`.
- `dmem_we`  out  1  registered; 1 = write.
- `dmem_addr`  out  DMEM_AW  registered; word-aligned address (`[1:0]` forced to 0).
- `dmem_wdata`  out  32  registered; write data.
- `dmem_be`  out  4  registered; byte enables, bit i = byte lane i.
- `dmem_ready`  in  1  memory completes the access this cycle.
- `dmem_rdata`  in  32  read data, valid when `dmem_ready`=1.
- `wb_regWrite`  out  1  registered; MEM/WB write enable.
- `wb_rd`  out  5  registered; MEM/WB destination.
- `wb_data`  out  32  registered; value to write back.
- `align_fault`  out  1  registered; one-cycle pulse on a misaligned word access.

## Operation
- FSM with states IDLE and WAIT. Reset state is IDLE.
- IDLE, no memory op (`memRead`=`memWrite`=0):
  - `stall`=0.
  - At the edge: `wb_regWrite`←`regWrite`, `wb_rd`←`rd`, `wb_data`←`result`.
- IDLE, misaligned word op (`word`=1 and `result[1:0]`≠0):
  - No memory request; `stall`=0.
  - At the edge: `align_fault`←1, `wb_regWrite`←0.
- IDLE, aligned memory op:
  - `stall`=1.
  - At the edge: go to WAIT; latch `rd`, `regWrite`, `memRead`, `word` and `result[1:0]`.
  - Drive `dmem_req`←1, `dmem_we`←`memWrite` and `dmem_addr`←{`result[DMEM_AW-1:2]`,2'b00}.
  - Byte enables: word access 4'b1111; byte access one-hot at lane `result[1:0]`.
  - `dmem_wdata`: word access = `readData2`; byte access = `readData2[7:0]` replicated to all four lanes.
  - `wb_regWrite`←0 (bubble).
- WAIT, `dmem_ready`=0:
  - `stall`=1; all dmem outputs held; EX/MEM inputs ignored.
  - `wb_regWrite`←0 each cycle.
- WAIT, `dmem_ready`=1:
  - `stall`=0, so upstream advances at this edge.
  - At the edge: `dmem_req`←0; go to IDLE.
  - Load: `wb_regWrite`←latched `regWrite`, `wb_rd`←latched `rd`.
  - Load data: word = `dmem_rdata`; byte = lane `dmem_rdata[8*a+7:8*a]` sign-extended to 32 bits, where a is the latched `result[1:0]`.
  - Store: `wb_regWrite`←0.
- `memRead` and `memWrite` both 1 is illegal; treated as a store.
- Reset outputs:
  - `stall`=0 combinationally once in IDLE.
  - `dmem_req`=`dmem_we`=0, `dmem_addr`=0, `dmem_wdata`=0, `dmem_be`=0.
  - `wb_regWrite`=0, `wb_rd`=0, `wb_data`=0, `align_fault`=0.
- Reset while in WAIT: abandon the access; `dmem_req` is 0 after the reset edge and no writeback occurs.

## Timing
- Non-memory instruction: 1 cycle; writeback registers update at the edge ending the cycle it is presented.
- Memory op, minimum 2 cycles: IDLE cycle (request issued at its edge), then a WAIT cycle with `dmem_ready`=1.
- Latency = 1 + N, where N = WAIT cycles until `dmem_ready`.
- `stall` is high for exactly N cycles per memory op (the IDLE issue cycle plus N−1 non-ready WAIT cycles).
- `dmem_req` rises one edge after the op is presented and falls at the edge ending the `dmem_ready` cycle.
- `dmem_ready` is sampled only in WAIT; a `dmem_ready` in IDLE is ignored.
- `align_fault` is high for exactly one cycle per faulting instruction.
- Back-to-back memory ops: the second is presented in the cycle after the first's ready cycle; its request rises one edge later, so `dmem_req` has one low cycle between accesses.

## Test plan
- Reset, then release with a NOP presented → every output 0, `stall`=0, FSM in IDLE.
- ALU op: `regWrite`=1, `rd`=5, `result`=0x1234 → next edge `wb_regWrite`=1, `wb_rd`=5, `wb_data`=0x1234; `dmem_req` stays 0.
- `lw` at 0x100, memory readies on the 3rd WAIT cycle with 0xDEADBEEF → `stall` high 3 cycles; `wb_data`=0xDEADBEEF after 4 cycles; `dmem_be`=4'b1111.
- `sb` at 0x102 with `readData2`=0x000000A5 → `dmem_be`=4'b0100, `dmem_wdata`=0xA5A5A5A5, `dmem_we`=1, `wb_regWrite`=0.
- `lb` at 0x203, `dmem_rdata`=0x80000000 → `wb_data`=0xFFFFFF80; `lw` at 0x202 → `align_fault` pulses, no `dmem_req`, `wb_regWrite`=0.
- `reset` asserted in the 2nd WAIT cycle → FSM back to IDLE, `dmem_req`=0 and `stall`=0 after the edge, no writeback.
